// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
// State and owner codes are fixed because the core decodes `owner` directly.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    localparam int STREAK_W = 4;

    // The memory returns a doubleword; byte address bit 2 picks the instruction word.
    function automatic logic [31:0] fetch_half(input logic [63:0] dw, input logic hi);
        return hi ? dw[63:32] : dw[31:0];
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Data-first priority pick with a saturating streak counter that bounds how
// long fetch can be starved by back-to-back data grants.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en_i,
    input  logic if_req_i,
    input  logic d_req_i,
    output logic grant_f_o,
    output logic grant_d_o
);

    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] streak_q, streak_d;

    always_comb begin
        grant_f_o = 1'b0;
        grant_d_o = 1'b0;
        streak_d  = streak_q;
        if (arb_en_i) begin
            if (if_req_i && d_req_i) begin
                if (streak_q < LIMIT) grant_d_o = 1'b1;
                else                  grant_f_o = 1'b1;
            end else if (d_req_i) begin
                grant_d_o = 1'b1;
            end else if (if_req_i) begin
                grant_f_o = 1'b1;
            end

            if (grant_d_o && if_req_i) begin
                if (streak_q != LIMIT) streak_d = streak_q + 1'b1;
            end else if (grant_f_o || !if_req_i) begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) streak_q <= '0;
        else       streak_q <= streak_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch and data ports.
// state | meaning: IDLE arbitrate, FETCH/DATA mem_req held until ack, RESP ready pulse then IDLE.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic [1:0]  owner
);

    arb_state_e  state_q;
    logic [1:0]  owner_q;
    logic        mem_req_q, mem_we_q;
    logic [63:0] mem_addr_q, mem_wdata_q;
    logic        if_ready_q, d_ready_q;
    logic [31:0] if_rdata_q;
    logic [63:0] d_rdata_q;
    logic        grant_f, grant_d;

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk       (clk),
        .reset     (reset),
        .arb_en_i  (state_q == ST_IDLE),
        .if_req_i  (if_req),
        .d_req_i   (d_req),
        .grant_f_o (grant_f),
        .grant_d_o (grant_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_f) begin
                        state_q     <= ST_FETCH;
                        owner_q     <= OWN_FETCH;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                    end else if (grant_d) begin
                        state_q     <= ST_DATA;
                        owner_q     <= OWN_DATA;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        state_q   <= ST_RESP;
                        mem_req_q <= 1'b0;
                        // A dropped if_req means the fetch was flushed; finish silently.
                        if (if_req) begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= fetch_half(mem_rdata, mem_addr_q[2]);
                        end
                    end
                end
                ST_DATA: begin
                    if (mem_ack) begin
                        state_q   <= ST_RESP;
                        mem_req_q <= 1'b0;
                        d_ready_q <= 1'b1;
                        d_rdata_q <= mem_we_q ? '0 : mem_rdata;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    owner_q <= OWN_NONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign owner     = owner_q;

endmodule
